// File: rtl/histogram_sequencer_if.sv
// Bundles the kernel arg_1 memory port, the physical bin-RAM port and the readout stream
// seen by the histogram sequencer; master is the sequencer side.
interface histogram_sequencer_if #(
    parameter int BIN_AW = 8,
    parameter int DATA_W = 32
);
    logic              kern_rst;
    logic              kern_valid;
    logic [BIN_AW-1:0] kern_raddr;
    logic [BIN_AW-1:0] kern_waddr;
    logic [DATA_W-1:0] kern_wdata;
    logic              kern_wen;
    logic [DATA_W-1:0] kern_rdata;

    logic [BIN_AW-1:0] ram_raddr;
    logic [BIN_AW-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [BIN_AW-1:0] out_bin;
    logic [DATA_W-1:0] out_count;
    logic              out_last;

    modport master (
        output kern_rst, kern_rdata,
        output ram_raddr, ram_waddr, ram_wdata, ram_wen,
        output out_valid, out_bin, out_count, out_last,
        input  kern_valid, kern_raddr, kern_waddr, kern_wdata, kern_wen,
        input  ram_rdata, out_ready
    );

    modport slave (
        input  kern_rst, kern_rdata,
        input  ram_raddr, ram_waddr, ram_wdata, ram_wen,
        input  out_valid, out_bin, out_count, out_last,
        output kern_valid, kern_raddr, kern_waddr, kern_wdata, kern_wen,
        output ram_rdata, out_ready
    );
endinterface

// File: rtl/histogram_sequencer.sv
// Sequences one histogram run: clear all bins, release the kernel onto the bin RAM,
// then stream every bin out over valid/ready.
module histogram_sequencer #(
    parameter int BIN_AW         = 8,
    parameter int DATA_W         = 32,
    parameter int NUM_BINS       = 256,
    parameter int MAX_RUN_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] run_cycles,
    histogram_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_RD_ADDR, S_RD_CAP, S_PRESENT, S_DONE
    } state_t;

    // One extra counter bit lets NUM_BINS == 2**BIN_AW terminate without wrapping.
    localparam int              LAST_BIN_I = NUM_BINS - 1;
    localparam logic [BIN_AW:0] LAST_BIN   = LAST_BIN_I[BIN_AW:0];
    localparam logic [31:0]     RUN_LIMIT  = MAX_RUN_CYCLES - 1;
    localparam bit              TIMEOUT_EN = (MAX_RUN_CYCLES != 0);

    state_t            state_q, state_d;
    logic [BIN_AW:0]   cnt_q, cnt_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] out_count_q, out_count_d;
    logic [BIN_AW-1:0] out_bin_q, out_bin_d;
    logic              out_last_q, out_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
            out_count_q  <= '0;
            out_bin_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            out_count_q  <= out_count_d;
            out_bin_q    <= out_bin_d;
            out_last_q   <= out_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        out_count_d  = out_count_q;
        out_bin_d    = out_bin_q;
        out_last_d   = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_CLEAR;
                    cnt_d        = '0;
                    run_cycles_d = '0;
                    timeout_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIN) state_d = S_RUN;
            end
            S_RUN: begin
                if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
                if (bus.kern_valid) begin
                    state_d = S_RD_ADDR;
                    cnt_d   = '0;
                end else if (TIMEOUT_EN && run_cycles_q == RUN_LIMIT) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                out_count_d = bus.ram_rdata;
                out_bin_d   = cnt_q[BIN_AW-1:0];
                out_last_d  = (cnt_q == LAST_BIN);
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything and must not disturb the sticky timeout flag.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            timeout_d = timeout_q;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        timeout        = timeout_q;
        run_cycles     = run_cycles_q;
        bus.kern_rst   = (state_q != S_RUN);
        bus.kern_rdata = bus.ram_rdata;
        bus.ram_raddr  = '0;
        bus.ram_waddr  = '0;
        bus.ram_wdata  = '0;
        bus.ram_wen    = 1'b0;
        bus.out_valid  = (state_q == S_PRESENT);
        bus.out_bin    = out_bin_q;
        bus.out_count  = out_count_q;
        bus.out_last   = out_last_q;
        case (state_q)
            S_CLEAR: begin
                bus.ram_wen   = 1'b1;
                bus.ram_waddr = cnt_q[BIN_AW-1:0];
            end
            S_RUN: begin
                bus.ram_raddr = bus.kern_raddr;
                bus.ram_waddr = bus.kern_waddr;
                bus.ram_wdata = bus.kern_wdata;
                bus.ram_wen   = bus.kern_wen;
            end
            S_RD_ADDR: bus.ram_raddr = cnt_q[BIN_AW-1:0];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed bench: bin RAM + kernel model around the main sequencer, plus a small
// instance with a 50-cycle RUN limit for the timeout path.
module tb_histogram_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort;
    logic        busy, done, timeout;
    logic [31:0] run_cycles;
    histogram_sequencer_if #(.BIN_AW(8), .DATA_W(32)) bus ();

    logic        start_to, abort_to;
    logic        busy_to, done_to, timeout_to;
    logic [31:0] run_cycles_to;
    histogram_sequencer_if #(.BIN_AW(2), .DATA_W(8)) bus_to ();

    histogram_sequencer #(.BIN_AW(8), .DATA_W(32), .NUM_BINS(256), .MAX_RUN_CYCLES(65535)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .timeout(timeout), .run_cycles(run_cycles), .bus(bus)
    );

    histogram_sequencer #(.BIN_AW(2), .DATA_W(8), .NUM_BINS(4), .MAX_RUN_CYCLES(50)) u_dut_to (
        .clk(clk), .rst(rst), .start(start_to), .abort(abort_to), .busy(busy_to), .done(done_to),
        .timeout(timeout_to), .run_cycles(run_cycles_to), .bus(bus_to)
    );

    assign bus_to.kern_valid = 1'b0;
    assign bus_to.kern_raddr = '0;
    assign bus_to.kern_waddr = '0;
    assign bus_to.kern_wdata = '0;
    assign bus_to.kern_wen   = 1'b0;
    assign bus_to.ram_rdata  = '0;
    assign bus_to.out_ready  = 1'b1;

    int passes = 0;
    int checks = 0;

    // Bin RAM model: 1-cycle synchronous read, write-enable write.
    logic [31:0] mem [256];
    logic [31:0] ram_rd = '0;
    logic        preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (bus.ram_wen) begin
            mem[bus.ram_waddr] <= bus.ram_wdata;
        end
        ram_rd <= mem[bus.ram_raddr];
    end
    assign bus.ram_rdata = ram_rd;

    // Readout consumer: fixed ready or pseudo-random backpressure.
    logic rdy_v = 1'b1, rand_rdy = 1'b0, rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.out_ready = rand_rdy ? rnd_bit : rdy_v;

    // Kernel model. Mode 0: valid at once; 1: 100 pixels, bin = i % 10, 2 cycles each; 2: never valid.
    int          kmode = 0;
    logic        kv, kwe;
    logic [7:0]  kra, kwa;
    logic [31:0] kwd;
    assign bus.kern_valid = kv;
    assign bus.kern_raddr = kra;
    assign bus.kern_waddr = kwa;
    assign bus.kern_wdata = kwd;
    assign bus.kern_wen   = kwe;
    initial begin
        int pix;
        int kph;
        kv = 1'b0; kwe = 1'b0; kra = '0; kwa = '0; kwd = '0; pix = 0; kph = 0;
        forever begin
            @(posedge clk); #1;
            kv = 1'b0; kwe = 1'b0; kra = '0; kwa = '0; kwd = '0;
            if (bus.kern_rst) begin
                pix = 0; kph = 0;
            end else if (kmode == 0) begin
                kv = 1'b1;
            end else if (kmode == 1) begin
                if (pix == 100) begin
                    kv = 1'b1;
                end else if (kph == 0) begin
                    kra = 8'(pix % 10); kph = 1;
                end else begin
                    kwa = 8'(pix % 10); kwd = bus.kern_rdata + 32'd1; kwe = 1'b1;
                    kph = 0; pix++;
                end
            end
        end
    end

    // Per-run monitor; counters restart when a start is accepted.
    logic [31:0] exp_bins [256];
    int          clr_wr = 0, clr_bad = 0, hs_cnt = 0, hs_bad = 0, stab_bad = 0, stall_cnt = 0, done_cnt = 0;
    longint      sum = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0]  pb = '0;
    logic [31:0] pc = '0;
    always @(negedge clk) begin
        if (start && !busy && !rst) begin
            clr_wr <= 0; clr_bad <= 0; hs_cnt <= 0; hs_bad <= 0;
            stab_bad <= 0; stall_cnt <= 0; done_cnt <= 0; sum <= 0;
        end else begin
            if (bus.ram_wen && bus.kern_rst) begin
                if (bus.ram_wdata != 32'd0 || int'(bus.ram_waddr) != clr_wr) clr_bad <= clr_bad + 1;
                clr_wr <= clr_wr + 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (int'(bus.out_bin) != hs_cnt || bus.out_count !== exp_bins[bus.out_bin]
                    || bus.out_last !== (bus.out_bin == 8'd255))
                    hs_bad <= hs_bad + 1;
                hs_cnt <= hs_cnt + 1;
                sum    <= sum + longint'(bus.out_count);
            end
            if (bus.out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 1;
            if (pv && !pr && bus.out_valid &&
                (bus.out_bin !== pb || bus.out_count !== pc || bus.out_last !== pl))
                stab_bad <= stab_bad + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
        pv <= bus.out_valid; pr <= bus.out_ready;
        pb <= bus.out_bin; pc <= bus.out_count; pl <= bus.out_last;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        step(); start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < bound);
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  tdone;
        logic [31:0] rc_last;
        logic        to_last;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_to = 1'b0; abort_to = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_timeout", 64'(timeout), 0);
        check("rst_kern_rst", 64'(bus.kern_rst), 1);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_out_last", 64'(bus.out_last), 0);
        check("rst_ram_wen", 64'(bus.ram_wen), 0);
        check("rst_run_cycles", 64'(run_cycles), 0);
        check("rst_addrs", {bus.ram_raddr, bus.ram_waddr, bus.out_bin}, 0);
        check("rst_data", {bus.ram_wdata, bus.out_count}, 0);
        step(); rst = 1'b0;

        // Clear check against a RAM full of ones, kernel finishes immediately.
        step(); preload = 1'b1; step(); preload = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk);
        check("t1_busy", 64'(busy), 1);
        check("t1_first_clear", {bus.ram_wen, bus.kern_rst, bus.ram_waddr}, {2'b11, 8'd0});
        wait_done(1500, "t1_done");
        check("t1_clear_writes", clr_wr, 256);
        check("t1_clear_bad", clr_bad, 0);
        check("t1_handshakes", hs_cnt, 256);
        check("t1_readout_bad", hs_bad, 0);
        check("t1_sum", sum, 0);
        check("t1_run_cycles", run_cycles, 1);
        @(negedge clk);
        check("t1_after", {done, busy}, 0);
        check("t1_done_cnt", done_cnt, 1);

        // Histogram of 100 pixels over bins 0..9.
        kmode = 1;
        for (int i = 0; i < 10; i++) exp_bins[i] = 32'd10;
        pulse_start();
        wait_done(1500, "t2_done");
        check("t2_handshakes", hs_cnt, 256);
        check("t2_readout_bad", hs_bad, 0);
        check("t2_sum", sum, 100);
        check("t2_run_cycles", run_cycles, 201);
        @(negedge clk);
        check("t2_done_cnt", done_cnt, 1);

        // Backpressure; the clear must also wipe the previous histogram.
        kmode = 0;
        for (int i = 0; i < 10; i++) exp_bins[i] = 32'd0;
        rand_rdy = 1'b1;
        pulse_start();
        wait_done(5000, "t3_done");
        rand_rdy = 1'b0;
        check("t3_handshakes", hs_cnt, 256);
        check("t3_readout_bad", hs_bad, 0);
        check("t3_stable", stab_bad, 0);
        check("t3_stalled", 64'(stall_cnt != 0), 1);
        @(negedge clk);
        check("t3_done_cnt", done_cnt, 1);

        // Timeout: 4 CLEAR cycles then 50 RUN cycles on the small instance.
        step(); start_to = 1'b1; step(); start_to = 1'b0;
        @(negedge clk);
        n = 0; tdone = 0; rc_last = '1; to_last = 1'b1;
        while (n < 200 && busy_to) begin
            if (done_to) tdone++;
            if (n == 53) begin rc_last = run_cycles_to; to_last = timeout_to; end
            n++;
            @(negedge clk);
        end
        check("to_busy_cycles", n, 54);
        check("to_last_run_cycle", {to_last, rc_last}, {1'b0, 32'd49});
        check("to_timeout", 64'(timeout_to), 1);
        check("to_run_cycles", run_cycles_to, 50);
        check("to_kern_rst", 64'(bus_to.kern_rst), 1);
        check("to_no_done", tdone, 0);
        step(); start_to = 1'b1; step(); start_to = 1'b0;
        @(negedge clk);
        check("to_restart", {timeout_to, busy_to}, 2'b01);
        abort_to = 1'b1; step(); abort_to = 1'b0;
        @(negedge clk);
        check("to_abort", {timeout_to, busy_to}, 2'b00);

        // Abort during CLEAR at bin 100.
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.ram_wen && bus.ram_waddr == 8'd100) && n < 400);
        check("ab1_reach", {bus.ram_wen, bus.ram_waddr}, {1'b1, 8'd100});
        abort = 1'b1; step(); abort = 1'b0;
        @(negedge clk);
        check("ab1_idle", {busy, bus.out_valid, bus.kern_rst, bus.ram_wen, done}, 5'b00100);
        check("ab1_clear_writes", clr_wr, 101);
        repeat (3) @(negedge clk);
        check("ab1_no_done", done_cnt, 0);

        // Abort while presenting bin 7.
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.out_valid && bus.out_bin == 8'd7) && n < 2000);
        check("ab2_reach", {bus.out_valid, bus.out_bin}, {1'b1, 8'd7});
        abort = 1'b1; step(); abort = 1'b0;
        @(negedge clk);
        check("ab2_idle", {busy, bus.out_valid, bus.kern_rst, done}, 4'b0010);
        check("ab2_handshakes", hs_cnt, 8);
        check("ab2_no_done", done_cnt, 0);
        pulse_start();
        wait_done(1500, "ab3_done");
        check("ab3_handshakes", hs_cnt, 256);
        check("ab3_readout_bad", hs_bad, 0);

        // Synchronous reset in the middle of RUN, with start held through it.
        kmode = 2;
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (bus.kern_rst && n < 400);
        check("rr_in_run", 64'(bus.kern_rst), 0);
        repeat (5) @(negedge clk);
        check("rr_run_cycles", run_cycles, 5);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        kmode = 0;
        @(negedge clk);
        check("rr_ctrl", {busy, done, timeout, bus.kern_rst, bus.out_valid, bus.out_last, bus.ram_wen}, 7'b0001000);
        check("rr_run_cycles0", run_cycles, 0);
        check("rr_bus0", {bus.ram_raddr, bus.ram_waddr, bus.out_bin, bus.out_count, bus.ram_wdata}, 0);
        step(); start = 1'b0;
        @(negedge clk);
        check("rr_restart", {busy, bus.ram_wen, bus.ram_waddr}, {2'b11, 8'd0});
        wait_done(1500, "rr_done");
        check("rr_handshakes", hs_cnt, 256);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
